// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with a multi-cycle unsigned shift-add multiply and a start/done handshake.
// Latency: single-cycle ops give done 1 cycle after the accepting edge; MULT gives done WIDTH+1 cycles after it.
// Backpressure: start is ignored while busy (MULT in progress); a start seen in DONE is accepted back-to-back.
//
// Ports:
//   clk, rst              single rising-edge clock, asynchronous active-high reset
//   start, alu_op, a, b   request and operands, captured on the accepting edge
//   result, result_hi     low / high result word (high word only nonzero for MULT)
//   zero, carry_out,      status flags, held until the next completed operation
//   overflow
//   busy, done            busy while multiplying; done pulses when outputs are fresh
module alu_nbit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] addend;
  logic [CW-1:0]      cnt;

  logic accept;
  logic last_step;

  // A request is only taken when not multiplying; DONE accepts so ops can issue every cycle.
  assign accept    = start && (state != S_MULT);
  assign last_step = (state == S_MULT) && (cnt == CW'(WIDTH - 1));

  assign busy = (state == S_MULT);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = (alu_op == OP_MULT) ? S_MULT : S_DONE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_MULT: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- single-cycle datapath
  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    // SUB and SLT share the adder as a + ~b + 1; ADD is plain a + b.
    sub_mode = (alu_op != OP_ADD);
    b_eff    = sub_mode ? ~b : b;
    sum_ext  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    sum      = sum_ext[WIDTH-1:0];
    add_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SLT: begin
        // Signed less-than: sign of the difference corrected by overflow.
        alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        alu_c   = sum_ext[WIDTH];
      end
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------- shift-add multiply
  always_comb begin
    addend  = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    acc_nxt = acc + addend;
  end

  // Outputs only change on a completed operation, so they hold across MULT and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      if (alu_op == OP_MULT) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result    <= alu_res;
        result_hi <= '0;
        zero      <= (alu_res == '0);
        carry_out <= alu_c;
        overflow  <= alu_v;
      end
    end else if (state == S_MULT) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        result    <= acc_nxt[WIDTH-1:0];
        result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
        zero      <= (acc_nxt == '0);
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq at WIDTH=32 and WIDTH=8.
// Drivers push expected responses (including the cycle done must appear in); monitors pop on done.
// Any done with an empty queue, or a late/early done, is reported.
module tb_alu_nbit_seq;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic        z;
    logic        c;
    logic        v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // 32-bit instance
  logic        rst32, start32, z32, c32, v32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32, hi32;
  // 8-bit instance
  logic        rst8, start8, z8, c8, v8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8, hi8;

  alu_nbit_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .start(start32), .alu_op(op32), .a(a32), .b(b32),
    .result(res32), .result_hi(hi32), .zero(z32), .carry_out(c32), .overflow(v32),
    .busy(busy32), .done(done32)
  );

  alu_nbit_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .alu_op(op8), .a(a8), .b(b8),
    .result(res8), .result_hi(hi8), .zero(z8), .carry_out(c8), .overflow(v8),
    .busy(busy8), .done(done8)
  );

  exp_t q32[$];
  exp_t q8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ------------------------------------------------------------ monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst32 && done32) begin
      if (q32.size() == 0) begin
        chk("w32_spurious_done", 64'(1), 64'(0));
      end else begin
        e = q32.pop_front();
        chk("w32_done_cycle", 64'(cyc), 64'(e.cyc));
        chk("w32_result", 64'(res32), e.res);
        chk("w32_result_hi", 64'(hi32), e.hi);
        chk("w32_zero", 64'(z32), 64'(e.z));
        chk("w32_carry", 64'(c32), 64'(e.c));
        chk("w32_overflow", 64'(v32), 64'(e.v));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst8 && done8) begin
      if (q8.size() == 0) begin
        chk("w8_spurious_done", 64'(1), 64'(0));
      end else begin
        e = q8.pop_front();
        chk("w8_done_cycle", 64'(cyc), 64'(e.cyc));
        chk("w8_result", 64'(res8), e.res);
        chk("w8_result_hi", 64'(hi8), e.hi);
        chk("w8_zero", 64'(z8), 64'(e.z));
        chk("w8_carry", 64'(c8), 64'(e.c));
        chk("w8_overflow", 64'(v8), 64'(e.v));
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic issue32(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] er, input logic [31:0] eh,
                         input logic z, input logic c, input logic v, input bit push);
    exp_t e;
    @(posedge clk); #1;
    start32 = 1'b1; op32 = op; a32 = aa; b32 = bb;
    if (push) begin
      e.res = 64'(er); e.hi = 64'(eh); e.z = z; e.c = c; e.v = v;
      e.cyc = cyc + ((op == OP_MULT) ? 33 : 1);
      q32.push_back(e);
    end
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] er, input logic [7:0] eh,
                        input logic z, input logic c, input logic v);
    exp_t e;
    @(posedge clk); #1;
    start8 = 1'b1; op8 = op; a8 = aa; b8 = bb;
    e.res = 64'(er); e.hi = 64'(eh); e.z = z; e.c = c; e.v = v;
    e.cyc = cyc + ((op == OP_MULT) ? 9 : 1);
    q8.push_back(e);
  endtask

  task automatic idle32();
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // After a MULT issue: the accepting edge, then unrelated start pulses that must be ignored.
  task automatic busy_pulses32();
    @(posedge clk); #1;
    chk("w32_busy_after_accept", 64'(busy32), 64'(1));
    for (int i = 0; i < 3; i++) begin
      start32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
      @(posedge clk); #1;
      chk("w32_busy_during_mult", 64'(busy32), 64'(1));
    end
    start32 = 1'b0;
  endtask

  task automatic busy_pulses8();
    @(posedge clk); #1;
    chk("w8_busy_after_accept", 64'(busy8), 64'(1));
    for (int i = 0; i < 3; i++) begin
      start8 = 1'b1; op8 = OP_AND; a8 = 8'h0F; b8 = 8'h0F;
      @(posedge clk); #1;
      chk("w8_busy_during_mult", 64'(busy8), 64'(1));
    end
    start8 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q32.size() != 0 || q8.size() != 0); i++) @(posedge clk);
  endtask

  task automatic chk_reset32(input string tag);
    chk({tag, "_result"}, 64'(res32), 64'(0));
    chk({tag, "_result_hi"}, 64'(hi32), 64'(0));
    chk({tag, "_flags"}, 64'({z32, c32, v32}), 64'(0));
    chk({tag, "_busy_done"}, 64'({busy32, done32}), 64'(0));
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst32 = 1'b1; start32 = 1'b0; op32 = OP_ADD; a32 = '0; b32 = '0;
    rst8  = 1'b1; start8  = 1'b0; op8  = OP_ADD; a8  = '0; b8  = '0;
    #1;
    chk_reset32("w32_reset");
    chk("w8_reset", 64'({res8, hi8, z8, c8, v8, busy8, done8}), 64'(0));
    repeat (2) @(posedge clk);
    #1; rst32 = 1'b0; rst8 = 1'b0;

    // Arithmetic corner cases, back-to-back.
    issue32(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 0, 1, 1);
    issue32(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 1, 0, 1);
    issue32(OP_SUB, 32'd5,        32'd5,        32'h00000000, 0, 1, 1, 0, 1);
    issue32(OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 1, 0, 1);
    issue32(OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0, 0, 1);
    idle32();
    drain();

    // Full-scale multiply with ignored start pulses while busy.
    issue32(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 1);
    busy_pulses32();
    drain();
    issue32(OP_MULT, 32'd3, 32'd5, 32'd15, 32'd0, 0, 0, 0, 1);
    idle32();
    drain();
    issue32(OP_MULT, 32'd0, 32'h12345678, 32'd0, 32'd0, 1, 0, 0, 1);
    idle32();
    drain();

    // Logic sweep, one op per cycle.
    issue32(OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 1);
    issue32(OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0, 0, 1);
    issue32(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1);
    issue32(OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, 1);
    idle32();
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("w32_result_hold", 64'(res32), 64'(32'hFFF0FFF0));

    // Reset in the middle of a multiply: no done, outputs cleared at once.
    issue32(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    idle32();
    repeat (9) @(posedge clk);
    #1;
    chk("w32_busy_before_abort", 64'(busy32), 64'(1));
    rst32 = 1'b1;
    #1;
    chk_reset32("w32_abort");
    @(posedge clk); #1;
    rst32 = 1'b0;
    repeat (40) @(posedge clk);
    issue32(OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1);
    idle32();
    drain();

    // Narrow instance.
    issue8(OP_MULT, 8'hFF, 8'h02, 8'hFE, 8'h01, 0, 0, 0);
    busy_pulses8();
    drain();
    issue8(OP_ADD, 8'h80, 8'h80, 8'h00, 8'h00, 1, 1, 1);
    issue8(OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h00, 0, 0, 0);
    issue8(OP_SLT, 8'h80, 8'h7F, 8'h01, 8'h00, 0, 1, 0);
    idle8();
    drain();

    repeat (3) @(posedge clk);
    chk("w32_queue_empty", 64'(q32.size()), 64'(0));
    chk("w8_queue_empty", 64'(q8.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
